// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory for the MEM stage, valid/ready request and response.
// Define DMEM_TRACE_EN to print one trace line per committed access.
module dmem_ctrl #(
    parameter int unsigned           DATA_WIDTH   = 64,
    parameter int unsigned           ADDR_WIDTH   = 64,
    parameter int unsigned           DEPTH        = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int unsigned           WAIT_CYCLES  = 1,
    parameter int unsigned           INIT_WORDS   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX = $clog2(DEPTH);
    localparam int unsigned SHW = LSB + 3;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

    function automatic mem_t f_init();
        mem_t v;
        for (int unsigned i = 0; i < DEPTH; i++)
            v[i] = (i < INIT_WORDS) ? DATA_WIDTH'(i) : 'x;
        return v;
    endfunction

    mem_t r_mem = f_init();

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_signed;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_commit;
    logic                    w_write;
    logic [1:0]              w_size;
    logic                    w_signed;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [31:0]             w_nbits;
    logic                    w_bad_size;
    logic                    w_misal;
    logic                    w_hit;
    logic                    w_err;
    logic [IDX-1:0]          w_idx;
    logic [SHW-1:0]          w_sh;
    logic [DATA_WIDTH-1:0]   w_mask;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   w_merge;
    logic [DATA_WIDTH-1:0]   w_raw;
    logic                    w_neg;
    logic [DATA_WIDTH-1:0]   w_load;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (req_valid)
                w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
    end

    // Capture request fields and run the wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_INIT;
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Decode uses live inputs when committing straight out of IDLE
    always_comb begin
        w_write  = (r_state == S_IDLE) ? req_write  : r_write;
        w_size   = (r_state == S_IDLE) ? req_size   : r_size;
        w_signed = (r_state == S_IDLE) ? req_signed : r_signed;
        w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
        w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
        w_nbits    = 32'd8 << w_size;
        w_bad_size = w_nbits > DATA_WIDTH;
        w_misal    = (4'(w_addr[2:0]) & ((4'd1 << w_size) - 4'd1)) != 4'd0;
        w_hit      = w_addr[ADDR_WIDTH-1:LSB+IDX]
                     == BASE_ADDRESS[ADDR_WIDTH-1:LSB+IDX];
        w_err      = !w_hit || w_bad_size || w_misal;
        w_idx      = w_addr[LSB+IDX-1:LSB];
        w_sh       = {w_addr[LSB-1:0], 3'b000};
        w_mask     = w_bad_size ? '1 : ~({DATA_WIDTH{1'b1}} << w_nbits);
        w_word     = r_mem[w_idx];
        w_merge    = (w_word & ~(w_mask << w_sh))
                     | ((w_wdata & w_mask) << w_sh);
        w_raw      = (w_word >> w_sh) & w_mask;
        w_neg      = |(w_raw & ~(w_mask >> 1));
        w_load     = (w_signed && w_neg) ? (w_raw | ~w_mask) : w_raw;
    end

    // Response registers load at the commit edge and hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_write) ? '0 : w_load;
        end
    end

    // Memory array is not reset; stores land at the commit edge
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_write && !w_err)
            r_mem[w_idx] <= w_merge;
    end

`ifdef DMEM_TRACE_EN
    // Access trace at each commit
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            $display("%0t %s addr=%h size=%0d data=%h err=%0b", $time,
                     w_write ? "W" : "R", w_addr, w_size,
                     w_write ? w_wdata : w_load, w_err);
            if (w_misal)
                $display("warning: unaligned address %h", w_addr);
            if (!w_hit)
                $display("warning: unmapped address %h", w_addr);
        end
    end
`endif

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors with a response scoreboard and monitor.
// Default parameters: 64-bit words, 64 words, one wait state.
module tb_dmem_ctrl;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;

    dmem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        string       nm;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   done  = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   acc;
        bit   pend;
        bit   seen;
        pend = 0;
        seen = 0;
        acc  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                seen = 0;
            end else begin
                if (req_valid && req_ready) begin
                    acc  = cyc;
                    pend = 1;
                    seen = 0;
                end
                if (resp_valid && pend && !seen) begin
                    seen = 1;
                    check("latency", 64'(cyc - acc), 64'(W + 1));
                end
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got %h want none",
                                 resp_rdata);
                    end else begin
                        e = sb.pop_front();
                        check({e.nm, "_rdata"}, resp_rdata, e.rdata);
                        check({e.nm, "_err"}, 64'(resp_err), 64'(e.err));
                    end
                    pend = 0;
                    done++;
                end
            end
        end
    end

    task automatic issue(input string nm, input logic wr,
                         input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] erd, input logic eer);
        exp_t e;
        e.nm = nm;
        e.rdata = erd;
        e.err = eer;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int k;
        k = 0;
        while (done == d0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (done == d0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no response want one", nm);
            sb.delete();
        end
    endtask

    task automatic xfer(input string nm, input logic wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] erd, input logic eer);
        int d0;
        d0 = done;
        issue(nm, wr, sz, sg, a, wd, erd, eer);
        wait_done(nm, d0);
    endtask

    initial begin : stim
        int d0;
        int k;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        #20;
        rst_n = 1'b1;

        xfer("ld_d_10", 0, 2'd3, 0, 64'h10, 0, 64'h2, 0);
        xfer("st_b_08", 1, 2'd0, 0, 64'h8, 64'hFF, 64'h0, 0);
        xfer("ld_bs_08", 0, 2'd0, 1, 64'h8, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        xfer("ld_bu_08", 0, 2'd0, 0, 64'h8, 0, 64'hFF, 0);
        xfer("ld_d_08", 0, 2'd3, 0, 64'h8, 0, 64'hFF, 0);
        xfer("st_h_1a", 1, 2'd1, 0, 64'h1A, 64'h1234_BEEF, 64'h0, 0);
        xfer("ld_d_18", 0, 2'd3, 0, 64'h18, 0, 64'h0000_0000_BEEF_0003, 0);
        xfer("ld_wu_18", 0, 2'd2, 0, 64'h18, 0, 64'h0000_0000_BEEF_0003, 0);
        xfer("ld_ws_18", 0, 2'd2, 1, 64'h18, 0, 64'hFFFF_FFFF_BEEF_0003, 0);
        xfer("ld_ws_1c", 0, 2'd2, 1, 64'h1C, 0, 64'h0, 0);
        xfer("ld_w_22", 0, 2'd2, 0, 64'h22, 0, 64'h0, 1);
        xfer("ld_d_2000", 0, 2'd3, 0, 64'h2000, 0, 64'h0, 1);
        xfer("st_d_2008", 1, 2'd3, 0, 64'h2008, 64'hDEAD, 64'h0, 1);
        xfer("ld_d_08b", 0, 2'd3, 0, 64'h8, 0, 64'hFF, 0);
        xfer("st_h_21", 1, 2'd1, 0, 64'h21, 64'hAAAA, 64'h0, 1);
        xfer("ld_d_20", 0, 2'd3, 0, 64'h20, 0, 64'h4, 0);

        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        d0 = done;
        issue("stall", 0, 2'd1, 1, 64'h1A, 0, 64'hFFFF_FFFF_FFFF_BEEF, 0);
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
            check("stall_err", 64'(resp_err), 64'd0);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_done("stall", d0);
        #1;
        check("post_hs_req_ready", 64'(req_ready), 64'd1);

        @(posedge clk);
        #1;
        req_write  = 1'b1;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'h30;
        req_wdata  = 64'h1234;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wait_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_rdata", resp_rdata, 64'd0);
        check("arst_err", 64'(resp_err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        xfer("ld_d_30", 0, 2'd3, 0, 64'h30, 0, 64'h6, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
